// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and constants for the load/store SRAM access controller.
// Holds the bus widths, FSM state encodings and the address range check.
package ram_access_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              TRUE         = 1'b1;
    localparam logic              FALSE        = 1'b0;
    localparam logic              WRITE_ENABLE = 1'b1;
    localparam logic              READ_ENABLE  = 1'b0;

    typedef enum logic [1:0] {
        RAM_ST_IDLE   = 2'd0,
        RAM_ST_ACCESS = 2'd1,
        RAM_ST_DONE   = 2'd2
    } ram_state_e;

    // Any byte-address bit above the SRAM word window makes the request unreachable.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                               input int unsigned       sram_aw);
        return (addr >> (sram_aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Memory-side responder for pipeline load/store requests: latches one request,
// runs a wait-stated access on an asynchronous SRAM and returns a one-cycle ready.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ram_en,
    input  logic                ram_write_en,
    input  logic [3:0]          ram_write_sel,
    input  logic [ADDR_W-1:0]   ram_addr,
    input  logic [DATA_W-1:0]   ram_write_data,
    output logic [DATA_W-1:0]   ram_read_data,
    output logic                ram_ready,
    output logic                bus_err,
    output logic                stall_req,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [3:0]          sram_be_n,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_data_oe,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ram_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 req_we_q;
    logic [3:0]           req_sel_q;
    logic [SRAM_AW-1:0]   req_addr_q;
    logic [DATA_W-1:0]    req_wdata_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 ready_q;
    logic                 bus_err_q;
    logic                 ce_n_q;
    logic                 oe_n_q;
    logic                 we_n_q;
    logic [3:0]           be_n_q;
    logic                 data_oe_q;

    logic                 req_oor_d;
    logic                 req_nop_d;
    logic                 req_is_store_d;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^ram_addr[1:0];

    always_comb begin
        req_is_store_d = (ram_write_en == WRITE_ENABLE);
        req_oor_d      = addr_out_of_range(ram_addr, SRAM_AW);
        req_nop_d      = req_is_store_d && (ram_write_sel == 4'b0000);
        cnt_d          = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RAM_ST_IDLE;
            cnt_q       <= '0;
            req_we_q    <= READ_ENABLE;
            req_sel_q   <= 4'b0000;
            req_addr_q  <= '0;
            req_wdata_q <= ZERO_WORD;
            rdata_q     <= ZERO_WORD;
            ready_q     <= FALSE;
            bus_err_q   <= FALSE;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            data_oe_q   <= FALSE;
        end else begin
            ready_q   <= FALSE;
            bus_err_q <= FALSE;
            case (state_q)
                RAM_ST_IDLE: begin
                    if (ram_en) begin
                        req_we_q    <= ram_write_en;
                        req_sel_q   <= ram_write_sel;
                        req_addr_q  <= ram_addr[SRAM_AW+1:2];
                        req_wdata_q <= ram_write_data;
                        cnt_q       <= CNT_LOAD;
                        if (req_oor_d || req_nop_d) begin
                            // Nothing to do on the SRAM: answer on the next cycle.
                            state_q   <= RAM_ST_DONE;
                            ready_q   <= TRUE;
                            bus_err_q <= req_oor_d;
                            rdata_q   <= ZERO_WORD;
                        end else begin
                            state_q   <= RAM_ST_ACCESS;
                            ce_n_q    <= 1'b0;
                            oe_n_q    <= req_is_store_d;
                            we_n_q    <= !req_is_store_d;
                            be_n_q    <= req_is_store_d ? ~ram_write_sel : 4'b0000;
                            data_oe_q <= req_is_store_d;
                        end
                    end
                end
                RAM_ST_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_d;
                        // Release WE one cycle early so data is held past the strobe edge.
                        if (cnt_q == CNT_ONE && req_we_q == WRITE_ENABLE) begin
                            we_n_q <= 1'b1;
                        end
                    end else begin
                        state_q   <= RAM_ST_DONE;
                        ready_q   <= TRUE;
                        rdata_q   <= (req_we_q == WRITE_ENABLE) ? ZERO_WORD : sram_rdata;
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        be_n_q    <= 4'b1111;
                        data_oe_q <= FALSE;
                    end
                end
                RAM_ST_DONE: begin
                    state_q <= RAM_ST_IDLE;
                end
                default: begin
                    state_q <= RAM_ST_IDLE;
                end
            endcase
        end
    end

    assign stall_req     = ((state_q == RAM_ST_IDLE) && ram_en) || (state_q == RAM_ST_ACCESS);
    assign ram_read_data = rdata_q;
    assign ram_ready     = ready_q;
    assign bus_err       = bus_err_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;
    assign sram_addr     = req_addr_q;
    assign sram_wdata    = req_wdata_q;
    assign sram_data_oe  = data_oe_q;

    logic [3:0] unused_sel;
    assign unused_sel = req_sel_q;

endmodule
